// File: rtl/in_fifo_sc.sv
// Single-clock 10-lane input FIFO: captures nibble lane data, optionally packs two
// nibbles per byte entry, and presents registered byte-wide lane data with level flags.
module in_fifo_sc #(
  parameter string ARRAY_MODE         = "ARRAY_MODE_4_X_8",
  parameter int    FIFO_DEPTH         = 8,
  parameter int    ALMOST_EMPTY_VALUE = 1,
  parameter int    ALMOST_FULL_VALUE  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WREN,
  input  logic       RDEN,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic [7:0] D5,
  input  logic [7:0] D6,
  input  logic [3:0] D7,
  input  logic [3:0] D8,
  input  logic [3:0] D9,
  output logic [7:0] Q0,
  output logic [7:0] Q1,
  output logic [7:0] Q2,
  output logic [7:0] Q3,
  output logic [7:0] Q4,
  output logic [7:0] Q5,
  output logic [7:0] Q6,
  output logic [7:0] Q7,
  output logic [7:0] Q8,
  output logic [7:0] Q9,
  output logic       EMPTY,
  output logic       FULL,
  output logic       ALMOSTEMPTY,
  output logic       ALMOSTFULL
);

  localparam bit PACK = (ARRAY_MODE == "ARRAY_MODE_4_X_8");
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] AF_LVL   = CW'(FIFO_DEPTH - ALMOST_FULL_VALUE);

  typedef enum logic {LO = 1'b0, HI = 1'b1} phase_t;

  phase_t        phase;
  logic [3:0]    hold [10];
  logic [7:0]    din [10];
  logic [79:0]   wdata_p0;
  logic [79:0]   mem [FIFO_DEPTH];
  logic [79:0]   q_p1;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_try;
  logic          push;
  logic          pop;

  // Only lanes 5/6 carry a full byte; the rest are zero-extended nibbles.
  assign din[0] = {4'h0, D0};
  assign din[1] = {4'h0, D1};
  assign din[2] = {4'h0, D2};
  assign din[3] = {4'h0, D3};
  assign din[4] = {4'h0, D4};
  assign din[5] = D5;
  assign din[6] = D6;
  assign din[7] = {4'h0, D7};
  assign din[8] = {4'h0, D8};
  assign din[9] = {4'h0, D9};

  // ---- stage p0: write entry assembly and push/pop qualification ----
  always_comb begin
    wdata_p0 = '0;
    for (int i = 0; i < 10; i++) begin
      if (PACK) wdata_p0[i*8 +: 8] = {din[i][3:0], hold[i]};
      else      wdata_p0[i*8 +: 8] = din[i];
    end
  end

  assign push_try = WREN && (!PACK || (phase == HI));
  assign push     = push_try && !FULL;
  assign pop      = RDEN && !EMPTY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      phase  <= LO;
      for (int i = 0; i < 10; i++) hold[i] <= 4'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A blocked high-nibble write leaves the held low nibble waiting in HI.
      if (PACK && WREN) begin
        if (phase == LO) begin
          for (int i = 0; i < 10; i++) hold[i] <= din[i][3:0];
          phase <= HI;
        end else if (push) begin
          phase <= LO;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata_p0;
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge CLK) begin
    if (RESET)    q_p1 <= '0;
    else if (pop) q_p1 <= mem[rd_ptr];
  end

  assign Q0 = q_p1[ 7: 0];
  assign Q1 = q_p1[15: 8];
  assign Q2 = q_p1[23:16];
  assign Q3 = q_p1[31:24];
  assign Q4 = q_p1[39:32];
  assign Q5 = q_p1[47:40];
  assign Q6 = q_p1[55:48];
  assign Q7 = q_p1[63:56];
  assign Q8 = q_p1[71:64];
  assign Q9 = q_p1[79:72];

  assign EMPTY       = (count == '0);
  assign FULL        = (count == FULL_LVL);
  assign ALMOSTEMPTY = (count <= AE_LVL);
  assign ALMOSTFULL  = (count >= AF_LVL);

endmodule
